// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: iterative shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier bit per clock
// Ports: clk, rst (async, active-high); in_valid/in_ready + A, B operand handshake;
//        out_valid/out_ready + R product handshake (R registered); busy = not idle.
// Optional: define SEQ_MULT_SIGNED_EN for two's-complement operands and product.
module seq_shift_add_mult #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   R,
   output logic                 busy
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
   logic [1:0] state;
   logic [2*WIDTH-1:0] aSh, acc, accNext, result;
   logic [WIDTH-1:0] bSh, aIn, bIn;
   logic [CW-1:0] cnt;
   assign in_ready  = state == IDLE;
   assign busy      = state != IDLE;
   assign out_valid = state == DONE;
   assign accNext   = acc + (bSh[0] ? aSh : '0);
`ifdef SEQ_MULT_SIGNED_EN
   logic sign;
   // magnitudes are WIDTH-bit unsigned, so the most negative value maps onto 2^(WIDTH-1)
   assign aIn    = A[WIDTH-1] ? -A : A;
   assign bIn    = B[WIDTH-1] ? -B : B;
   assign result = sign ? -accNext : accNext;
   always_ff @(posedge clk or posedge rst)
      if (rst) sign <= 1'b0;
      else if (state == IDLE && in_valid) sign <= A[WIDTH-1] ^ B[WIDTH-1];
`else
   assign aIn    = A;
   assign bIn    = B;
   assign result = accNext;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         aSh   <= '0;
         bSh   <= '0;
         acc   <= '0;
         cnt   <= '0;
         R     <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               aSh   <= {{WIDTH{1'b0}}, aIn};
               bSh   <= bIn;
               acc   <= '0;
               cnt   <= '0;
               state <= BUSY;
            end
            BUSY: begin
               acc <= accNext;
               aSh <= aSh << 1;
               bSh <= bSh >> 1;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  R     <= result;
                  state <= DONE;
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb_seq_shift_add_mult: directed self-checking bench for seq_shift_add_mult at WIDTH=4
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// Define SEQ_MULT_SIGNED_EN for both files to exercise the signed build.
module tb_seq_shift_add_mult;
   logic clk = 1'b0;
   logic rst, in_valid, in_ready, out_valid, out_ready, busy;
   logic [3:0] A, B;
   logic [7:0] R;
   int vectors = 0;
   int miscompares = 0;

   seq_shift_add_mult #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
      .out_valid(out_valid), .out_ready(out_ready), .R(R), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // accept one operand pair, measure latency, check the product, then drain it
   task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp, input string tag);
      int lat;
      A = a;
      B = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      A = ~a;
      B = ~b;
      chk({tag, "_in_ready_busy"}, {15'd0, in_ready}, 16'd0);
      chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
      lat = 0;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 16'(lat), 16'd4);
      chk({tag, "_R"}, {8'd0, R}, {8'd0, exp});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_drain_ov"}, {15'd0, out_valid}, 16'd0);
      chk({tag, "_drain_ir"}, {15'd0, in_ready}, 16'd1);
   endtask

   initial begin
      int lat;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      A = '0;
      B = '0;
      @(negedge clk);
      chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
      chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_R", {8'd0, R}, 16'd0);
      rst = 1'b0;
      @(negedge clk);
`ifdef SEQ_MULT_SIGNED_EN
      run(4'h8, 4'h8, 8'h40, "s_m8_m8");
      run(4'h8, 4'h7, 8'hC8, "s_m8_7");
      run(4'hF, 4'h0, 8'h00, "s_m1_0");
      run(4'hF, 4'hF, 8'h01, "s_m1_m1");
      run(4'h3, 4'hE, 8'hFA, "s_3_m2");
      run(4'h0, 4'h8, 8'h00, "s_0_m8");
`else
      run(4'd15, 4'd15, 8'hE1, "u_15_15");
      run(4'd9, 4'd0, 8'h00, "u_9_0");
      run(4'd0, 4'd9, 8'h00, "u_0_9");
      // backpressure: product held for 10 cycles while new operands are offered
      A = 4'd13;
      B = 4'd11;
      in_valid = 1'b1;
      @(negedge clk);
      A = 4'd2;
      B = 4'd2;
      lat = 0;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk("bp_latency", 16'(lat), 16'd4);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_R", {8'd0, R}, 16'h008F);
         chk("bp_out_valid", {15'd0, out_valid}, 16'd1);
         chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_release_ov", {15'd0, out_valid}, 16'd0);
      chk("bp_release_ir", {15'd0, in_ready}, 16'd1);
      // asynchronous reset two steps into an operation
      A = 4'd7;
      B = 4'd5;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", {15'd0, in_ready}, 16'd1);
      chk("mid_rst_out_valid", {15'd0, out_valid}, 16'd0);
      chk("mid_rst_busy", {15'd0, busy}, 16'd0);
      chk("mid_rst_R", {8'd0, R}, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run(4'd3, 4'd6, 8'h12, "u_after_rst");
      // every operand pair, consumer always ready
      out_ready = 1'b1;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            A = 4'(a);
            B = 4'(b);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 10) begin
               @(negedge clk);
               lat++;
            end
            chk("exh_R", {8'd0, R}, 16'(a * b));
            @(negedge clk);
            chk("exh_in_ready", {15'd0, in_ready}, 16'd1);
         end
      end
      out_ready = 1'b0;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
